// File: rtl/alu_seq_divider_pkg.sv
// Shared types and constants for the sequential divider.
// Contents:
//   div_state_t     - divider FSM state encoding (IDLE, BUSY, DONE)
//   DIV_WIDTH       - default operand/result width
//   DIV_BY_ZERO_QUO - quotient reported for a zero divisor (all ones)
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUO = '1;

endpackage

// File: rtl/alu_seq_divider_if.sv
// Divide request/stall interface between the execute-stage ALU (master)
// and the sequential divider (slave).
// Signals:
//   is_div - divide/modulo request level, held while stall is high (master)
//   A, B   - unsigned dividend/divisor, stable while requesting (master)
//   stall  - pipeline freeze until the result is ready (slave)
//   quo    - registered quotient (slave)
//   rem    - registered remainder (slave)
interface alu_seq_divider_if
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             is_div;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             stall;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  modport master (
    output is_div,
    output A,
    output B,
    input  stall,
    input  quo,
    input  rem
  );

  modport slave (
    input  is_div,
    input  A,
    input  B,
    output stall,
    output quo,
    output rem
  );

endinterface

// File: rtl/alu_seq_divider_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   i_rem_p        - current partial remainder (WIDTH+1 bits)
//   i_dividend_msb - dividend bit shifted into the partial remainder
//   i_divisor      - divisor
//   o_rem_next     - partial remainder after the trial subtraction/restore
//   o_q_bit        - quotient bit produced by this iteration
module alu_div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem_p,
  input  logic             i_dividend_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem_next,
  output logic             o_q_bit
);

  // One extra bit above the partial remainder gives the trial difference a
  // sign bit; the partial remainder is always below the divisor, so the
  // shifted value itself still fits in WIDTH+1 bits.
  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_diff;

  assign w_shifted = {i_rem_p, i_dividend_msb};
  assign w_diff    = w_shifted - {2'b00, i_divisor};

  // Keep the difference when it is non-negative, otherwise restore.
  always_comb begin
    o_rem_next = w_shifted[WIDTH:0];
    o_q_bit    = 1'b0;
    if (!w_diff[WIDTH+1]) begin
      o_rem_next = w_diff[WIDTH:0];
      o_q_bit    = 1'b1;
    end else begin
      o_rem_next = w_shifted[WIDTH:0];
      o_q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider, responder side of the
// ALU divide request/stall interface.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of alu_seq_divider_if (is_div, A, B in;
//           stall, quo, rem out)
// A request with B != 0 holds stall for WIDTH+1 cycles (request cycle plus
// WIDTH iterations); B == 0 finishes after the request cycle alone.
module alu_seq_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_seq_divider_if.slave  bus
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem_p;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;

  alu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem_p        (r_rem_p),
    .i_dividend_msb (r_dividend[WIDTH-1]),
    .i_divisor      (r_divisor),
    .o_rem_next     (w_rem_next),
    .o_q_bit        (w_q_bit)
  );

  // Stall rises with the request itself (no bubble) and is forced low while
  // reset is held, since the state register alone would let is_div through.
  assign bus.stall = rst_n & bus.is_div & (r_state != DONE);
  assign bus.quo   = r_quo;
  assign bus.rem   = r_rem;

  // Divider FSM: operand latch, one iteration per BUSY cycle, result write.
  // The dividend register doubles as the quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_dividend <= {WIDTH{1'b0}};
      r_divisor  <= {WIDTH{1'b0}};
      r_rem_p    <= {(WIDTH+1){1'b0}};
      r_quo      <= {WIDTH{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.is_div) begin
            if (bus.B == {WIDTH{1'b0}}) begin
              r_quo   <= {WIDTH{DIV_BY_ZERO_QUO[0]}};
              r_rem   <= bus.A;
              r_state <= DONE;
            end else begin
              r_dividend <= bus.A;
              r_divisor  <= bus.B;
              r_rem_p    <= {(WIDTH+1){1'b0}};
              r_cnt      <= CNT_W'(WIDTH);
              r_state    <= BUSY;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (!bus.is_div) begin
            // Pipeline flush: abandon the operation, results untouched.
            r_state <= IDLE;
          end else begin
            r_rem_p    <= w_rem_next;
            r_dividend <= {r_dividend[WIDTH-2:0], w_q_bit};
            r_cnt      <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_quo   <= {r_dividend[WIDTH-2:0], w_q_bit};
              r_rem   <= w_rem_next[WIDTH-1:0];
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        DONE: begin
          // Always leave DONE so a still-high is_div is not re-taken as the
          // same instruction; a new request is recognised from IDLE.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
